lieat_idu_scoreboard: RTL and testbench

- Parametrised outstanding-instruction tracker in IDU dispatch; successor of the fixed 7-slot OITF.
- One circular tracker per execution-unit class (NUM_UNITS channels, UNIT_DEPTH entries each) records rd of in-flight long-latency ops.
- Produces dispatch RAW/WAW stall, per-unit full/empty/count, and NUM_LOOKUP early-lookup dependency flags for IF-stage rs reads.

---
 rtl/lieat_idu_scoreboard_pkg.sv | 26 ++
 rtl/lieat_idu_sb_unit.sv | 128 ++++++++++++
 rtl/lieat_idu_scoreboard.sv | 96 +++++++++
 tb/tb_lieat_idu_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_idu_scoreboard_pkg.sv
// Shared definitions for the IDU outstanding-instruction scoreboard.
// Provides the register index width, unit class indices, the default set of
// units that take part in dependency matching, and the index-compare helper.
package lieat_idu_scoreboard_pkg;

  localparam int unsigned RegIdx      = 5;
  localparam int unsigned NumUnitsDef = 5;

  localparam int unsigned UnitCom    = 0;
  localparam int unsigned UnitLsu    = 1;
  localparam int unsigned UnitMuldiv = 2;
  localparam int unsigned UnitVpu    = 3;
  localparam int unsigned UnitFpu    = 4;

  // Only long-latency units (muldiv, vpu, fpu) are hazard-checked by default.
  localparam logic [NumUnitsDef-1:0] DefaultCheckMask = 5'b11100;

  // True when a pending rd equals the queried index, with x0 optionally
  // excluded because it can never carry a real dependency.
  function automatic logic idx_hit(input logic [RegIdx-1:0] rd,
                                   input logic [RegIdx-1:0] idx,
                                   input logic              skip_x0);
    return (rd == idx) && !(skip_x0 && (idx == '0));
  endfunction

endpackage

// File: rtl/lieat_idu_sb_unit.sv
// One execution-unit class ring of in-flight destination registers.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop all entries (beats same-cycle alloc/retire)
//   alloc_i              accepted dispatch into this unit
//   wbck_i               writeback request for this unit
//   disp_*_i             dispatch operand/destination indices and enables
//   lk_rs_i              early-lookup indices, port k at [k*RegIdx +: RegIdx]
//   disp_dep_o           dispatch operand hits a pending rd of this unit
//   lk_dep_o             per-lookup hit on a pending rd of this unit
//   full_o               no free slot once this cycle's retire/flush is applied
//   empty_o, cnt_o       registered occupancy state
//   wbck_err_o           writeback request while empty (pulse)
module lieat_idu_sb_unit
  import lieat_idu_scoreboard_pkg::*;
#(
  parameter int unsigned UnitDepth = 2,
  parameter int unsigned NumLookup = 1,
  parameter bit          CheckEn   = 1'b1,
  parameter bit          SkipX0    = 1'b1,
  localparam int unsigned PtrW     = $clog2(UnitDepth) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          alloc_i,
  input  logic                          wbck_i,
  input  logic                          disp_rs1en_i,
  input  logic                          disp_rs2en_i,
  input  logic                          disp_rdwen_i,
  input  logic [RegIdx-1:0]             disp_rs1_i,
  input  logic [RegIdx-1:0]             disp_rs2_i,
  input  logic [RegIdx-1:0]             disp_rd_i,
  input  logic [NumLookup*RegIdx-1:0]   lk_rs_i,
  output logic                          disp_dep_o,
  output logic [NumLookup-1:0]          lk_dep_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [PtrW-1:0]               cnt_o,
  output logic                          wbck_err_o
);

  localparam int unsigned IdxW = (UnitDepth > 1) ? $clog2(UnitDepth) : 1;

  logic [UnitDepth-1:0] valid_q, valid_d, rdwen_q, rdwen_d, eff_vld;
  logic [RegIdx-1:0]    rd_q [UnitDepth];
  logic [RegIdx-1:0]    rd_d [UnitDepth];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, cnt;
  logic [IdxW-1:0]      widx, ridx;
  logic                 empty, retire, do_alloc;

  // Pointer MSB is the wrap bit, so the difference is the occupancy 0..UnitDepth.
  assign cnt   = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign widx  = (UnitDepth > 1) ? wptr_q[IdxW-1:0] : '0;
  assign ridx  = (UnitDepth > 1) ? rptr_q[IdxW-1:0] : '0;

  assign retire     = wbck_i & ~empty & ~flush_i;
  assign do_alloc   = alloc_i & ~flush_i;
  assign wbck_err_o = wbck_i & empty;

  assign full_o  = ~flush_i & ((cnt - PtrW'(retire)) == PtrW'(UnitDepth));
  assign empty_o = empty;
  assign cnt_o   = cnt;

  // Entries leaving this cycle no longer count as hazards.
  always_comb begin
    for (int i = 0; i < UnitDepth; i++) begin
      eff_vld[i] = valid_q[i] & ~flush_i & ~(retire && (ridx == IdxW'(i)));
    end
  end

  always_comb begin
    disp_dep_o = 1'b0;
    lk_dep_o   = '0;
    for (int i = 0; i < UnitDepth; i++) begin
      if (CheckEn && eff_vld[i] && rdwen_q[i]) begin
        if (disp_rs1en_i && idx_hit(rd_q[i], disp_rs1_i, SkipX0)) disp_dep_o = 1'b1;
        if (disp_rs2en_i && idx_hit(rd_q[i], disp_rs2_i, SkipX0)) disp_dep_o = 1'b1;
        if (disp_rdwen_i && idx_hit(rd_q[i], disp_rd_i, SkipX0))  disp_dep_o = 1'b1;
        for (int k = 0; k < NumLookup; k++) begin
          if (idx_hit(rd_q[i], lk_rs_i[k*RegIdx +: RegIdx], SkipX0)) lk_dep_o[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdwen_d = rdwen_q;
    rd_d    = rd_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      valid_d = '0;
      rptr_d  = wptr_q;
    end else begin
      // Clear before set: with one slot, retire and alloc hit the same entry.
      if (retire) begin
        valid_d[ridx] = 1'b0;
        rptr_d        = rptr_q + 1'b1;
      end
      if (do_alloc) begin
        valid_d[widx] = 1'b1;
        rdwen_d[widx] = disp_rdwen_i;
        rd_d[widx]    = disp_rd_i;
        wptr_d        = wptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      rdwen_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      for (int i = 0; i < UnitDepth; i++) rd_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      rdwen_q <= rdwen_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: rtl/lieat_idu_scoreboard.sv
// Outstanding-instruction scoreboard for IDU dispatch: one ring per unit class.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                per-unit flush
//   disp_*_i               dispatch fire, one-hot target unit, operand indices
//   wbck_ena_i, wbck_op_i  writeback fire, one-hot retiring unit
//   lk_rs_i / lk_dep_o     early-lookup indices and their pending-rd hits
//   disp_condition_o       dispatch allowed (no hazard, target not full)
//   unit_full_o, unit_empty_o, unit_cnt_o, all_empty_o  occupancy status
//   wbck_err_o             sticky: writeback seen on an empty unit
module lieat_idu_scoreboard
  import lieat_idu_scoreboard_pkg::*;
#(
  parameter int unsigned          NumUnits  = NumUnitsDef,
  parameter int unsigned          UnitDepth = 2,
  parameter int unsigned          NumLookup = 1,
  parameter logic [NumUnits-1:0]  CheckMask = NumUnits'(DefaultCheckMask),
  parameter bit                   SkipX0    = 1'b1,
  localparam int unsigned         CntW      = $clog2(UnitDepth) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumUnits-1:0]           flush_i,
  input  logic                          disp_ena_i,
  input  logic [NumUnits-1:0]           disp_op_i,
  input  logic                          disp_rs1en_i,
  input  logic                          disp_rs2en_i,
  input  logic                          disp_rdwen_i,
  input  logic [RegIdx-1:0]             disp_rs1_i,
  input  logic [RegIdx-1:0]             disp_rs2_i,
  input  logic [RegIdx-1:0]             disp_rd_i,
  input  logic                          wbck_ena_i,
  input  logic [NumUnits-1:0]           wbck_op_i,
  input  logic [NumLookup*RegIdx-1:0]   lk_rs_i,
  output logic [NumLookup-1:0]          lk_dep_o,
  output logic                          disp_condition_o,
  output logic [NumUnits-1:0]           unit_full_o,
  output logic [NumUnits-1:0]           unit_empty_o,
  output logic [NumUnits*CntW-1:0]      unit_cnt_o,
  output logic                          all_empty_o,
  output logic                          wbck_err_o
);

  logic [NumUnits-1:0]                 unit_dep, unit_err;
  logic [NumUnits-1:0][NumLookup-1:0]  unit_lk;
  logic                                wbck_err_q;

  for (genvar u = 0; u < NumUnits; u++) begin : g_unit
    lieat_idu_sb_unit #(
      .UnitDepth (UnitDepth),
      .NumLookup (NumLookup),
      .CheckEn   (CheckMask[u]),
      .SkipX0    (SkipX0)
    ) u_unit (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i[u]),
      .alloc_i      (disp_ena_i & disp_op_i[u] & disp_condition_o),
      .wbck_i       (wbck_ena_i & wbck_op_i[u]),
      .disp_rs1en_i (disp_rs1en_i),
      .disp_rs2en_i (disp_rs2en_i),
      .disp_rdwen_i (disp_rdwen_i),
      .disp_rs1_i   (disp_rs1_i),
      .disp_rs2_i   (disp_rs2_i),
      .disp_rd_i    (disp_rd_i),
      .lk_rs_i      (lk_rs_i),
      .disp_dep_o   (unit_dep[u]),
      .lk_dep_o     (unit_lk[u]),
      .full_o       (unit_full_o[u]),
      .empty_o      (unit_empty_o[u]),
      .cnt_o        (unit_cnt_o[u*CntW +: CntW]),
      .wbck_err_o   (unit_err[u])
    );
  end

  // Full depends only on retire/flush, never on alloc, so there is no loop here.
  assign disp_condition_o = ~(|unit_dep) & ~(|(disp_op_i & unit_full_o));
  assign all_empty_o      = &unit_empty_o;
  assign wbck_err_o       = wbck_err_q;

  always_comb begin
    lk_dep_o = '0;
    for (int u = 0; u < NumUnits; u++) lk_dep_o = lk_dep_o | unit_lk[u];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wbck_err_q <= 1'b0;
    else         wbck_err_q <= wbck_err_q | (|unit_err);
  end

  disp_op_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    disp_ena_i |-> $onehot(disp_op_i));
  wbck_op_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    wbck_ena_i |-> $onehot(wbck_op_i));

endmodule

// File: tb/tb_lieat_idu_scoreboard.sv
module tb_lieat_idu_scoreboard;
  import lieat_idu_scoreboard_pkg::*;

  localparam int unsigned NU = 5;
  localparam logic [NU-1:0] OpCom = 5'b00001, OpLsu = 5'b00010, OpMul = 5'b00100,
                            OpVpu = 5'b01000, OpFpu = 5'b10000;
  localparam int SelCond = 0, SelLk = 1, SelFull = 2, SelEmpty = 3, SelCnt = 4,
                 SelAllEmpty = 5, SelErr = 6;

  logic clk, rst_n;
  logic [NU-1:0] flush, disp_op, wbck_op;
  logic disp_ena, rs1en, rs2en, rdwen, wbck_ena;
  logic [RegIdx-1:0] rs1, rs2, rd, lk_rs;
  logic [0:0] lk_dep;
  logic disp_condition, all_empty, wbck_err;
  logic [NU-1:0] unit_full, unit_empty;
  logic [NU*2-1:0] unit_cnt;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];
  int n_assert = 0;
  int n_fail = 0;

  lieat_idu_scoreboard dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .disp_ena_i       (disp_ena),
    .disp_op_i        (disp_op),
    .disp_rs1en_i     (rs1en),
    .disp_rs2en_i     (rs2en),
    .disp_rdwen_i     (rdwen),
    .disp_rs1_i       (rs1),
    .disp_rs2_i       (rs2),
    .disp_rd_i        (rd),
    .wbck_ena_i       (wbck_ena),
    .wbck_op_i        (wbck_op),
    .lk_rs_i          (lk_rs),
    .lk_dep_o         (lk_dep),
    .disp_condition_o (disp_condition),
    .unit_full_o      (unit_full),
    .unit_empty_o     (unit_empty),
    .unit_cnt_o       (unit_cnt),
    .all_empty_o      (all_empty),
    .wbck_err_o       (wbck_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelCond:     return 32'(disp_condition);
      SelLk:       return 32'(lk_dep);
      SelFull:     return 32'(unit_full);
      SelEmpty:    return 32'(unit_empty);
      SelCnt:      return 32'(unit_cnt);
      SelAllEmpty: return 32'(all_empty);
      default:     return 32'(wbck_err);
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    sb_q.push_back('{tag: tag, sel: sel, exp: val});
  endtask

  // Drain the scoreboard against the settled outputs, well before the next edge.
  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = observe(e.sel);
      n_assert++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    flush = '0; disp_ena = 0; disp_op = '0; rs1en = 0; rs2en = 0; rdwen = 0;
    rs1 = '0; rs2 = '0; rd = '0; wbck_ena = 0; wbck_op = '0; lk_rs = '0;
  endtask

  task automatic disp(input logic [NU-1:0] op, input logic e1, input logic [4:0] r1,
                      input logic e2, input logic [4:0] r2, input logic ew,
                      input logic [4:0] rw);
    disp_ena = 1; disp_op = op; rs1en = e1; rs1 = r1; rs2en = e2; rs2 = r2;
    rdwen = ew; rd = rw;
  endtask

  task automatic wbck(input logic [NU-1:0] op);
    wbck_ena = 1; wbck_op = op;
  endtask

  initial begin
    rst_n = 1'b1;
    step();
    #1 rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;

    // Reset state
    expect_val("rst_empty", SelEmpty, 32'h1f);
    expect_val("rst_cnt", SelCnt, 32'h0);
    expect_val("rst_cond", SelCond, 32'h1);
    expect_val("rst_lk", SelLk, 32'h0);
    expect_val("rst_all_empty", SelAllEmpty, 32'h1);
    expect_val("rst_full", SelFull, 32'h0);
    expect_val("rst_err", SelErr, 32'h0);
    check_all();

    // muldiv RAW stall, released by same-cycle writeback
    step(); disp(OpMul, 0, 0, 0, 0, 1, 7);
    expect_val("mul_first_cond", SelCond, 32'h1); check_all();
    step(); disp(OpMul, 1, 7, 0, 0, 0, 0); lk_rs = 7;
    expect_val("mul_raw_cond", SelCond, 32'h0);
    expect_val("mul_raw_lk", SelLk, 32'h1);
    expect_val("mul_cnt1", SelCnt, 32'h010);
    expect_val("mul_empty", SelEmpty, 32'h1b);
    check_all();
    step(); disp(OpMul, 1, 7, 0, 0, 0, 0); lk_rs = 7; wbck(OpMul);
    expect_val("mul_retire_cond", SelCond, 32'h1);
    expect_val("mul_retire_lk", SelLk, 32'h0);
    check_all();
    step(); wbck(OpMul);
    expect_val("mul_cnt_kept", SelCnt, 32'h010); check_all();
    step();
    expect_val("mul_drained", SelAllEmpty, 32'h1); check_all();

    // lsu fill, full, dispatch+retire same cycle
    step(); disp(OpLsu, 0, 0, 0, 0, 1, 3); check_all();
    step(); disp(OpLsu, 0, 0, 0, 0, 1, 4);
    expect_val("lsu_cnt1", SelCnt, 32'h004);
    expect_val("lsu_not_full", SelFull, 32'h0);
    check_all();
    step(); lk_rs = 3;
    expect_val("lsu_full", SelFull, 32'h02);
    expect_val("lsu_cnt2", SelCnt, 32'h008);
    expect_val("lsu_lk_unchecked", SelLk, 32'h0);
    check_all();
    step(); disp(OpLsu, 0, 0, 0, 0, 1, 9); wbck(OpLsu);
    expect_val("lsu_full_retiring", SelFull, 32'h0);
    expect_val("lsu_swap_cond", SelCond, 32'h1);
    check_all();
    step(); disp(OpLsu, 0, 0, 0, 0, 1, 10);
    expect_val("lsu_swap_cnt", SelCnt, 32'h008);
    expect_val("lsu_full_cond", SelCond, 32'h0);
    check_all();

    // flush beats same-cycle dispatch
    step(); flush = OpLsu; disp(OpLsu, 0, 0, 0, 0, 1, 3); lk_rs = 3;
    expect_val("flush_full", SelFull, 32'h0);
    expect_val("flush_cond", SelCond, 32'h1);
    check_all();
    step(); lk_rs = 3;
    expect_val("flush_cnt", SelCnt, 32'h0);
    expect_val("flush_empty", SelEmpty, 32'h1f);
    expect_val("flush_lk", SelLk, 32'h0);
    check_all();

    // com: not hazard-checked, stalls only on full
    step(); disp(OpCom, 0, 0, 0, 0, 1, 5); check_all();
    step(); disp(OpCom, 1, 5, 0, 0, 1, 6); lk_rs = 5;
    expect_val("com_no_raw", SelCond, 32'h1);
    expect_val("com_no_lk", SelLk, 32'h0);
    check_all();
    step(); disp(OpCom, 0, 0, 0, 0, 1, 8);
    expect_val("com_full_cond", SelCond, 32'h0);
    expect_val("com_full", SelFull, 32'h01);
    expect_val("com_cnt2", SelCnt, 32'h002);
    check_all();
    step(); flush = OpCom; check_all();
    step();
    expect_val("com_flushed", SelAllEmpty, 32'h1); check_all();

    // writeback on empty fpu, x0 never matches
    step(); wbck(OpFpu);
    expect_val("err_before", SelErr, 32'h0); check_all();
    step();
    expect_val("err_set", SelErr, 32'h1);
    expect_val("err_cnt", SelCnt, 32'h0);
    expect_val("err_empty", SelEmpty, 32'h1f);
    check_all();
    step(); disp(OpMul, 0, 0, 0, 0, 1, 0);
    expect_val("err_sticky", SelErr, 32'h1); check_all();
    step(); disp(OpMul, 1, 0, 0, 0, 1, 0); lk_rs = 0;
    expect_val("x0_cond", SelCond, 32'h1);
    expect_val("x0_lk", SelLk, 32'h0);
    expect_val("x0_cnt", SelCnt, 32'h010);
    check_all();
    step();
    expect_val("x0_cnt2", SelCnt, 32'h020);
    expect_val("x0_full", SelFull, 32'h04);
    check_all();

    // cross-unit WAW and rs2 RAW against vpu
    step(); disp(OpVpu, 0, 0, 0, 0, 1, 12); check_all();
    step(); disp(OpFpu, 0, 0, 0, 0, 1, 12); lk_rs = 12;
    expect_val("waw_cond", SelCond, 32'h0);
    expect_val("waw_lk", SelLk, 32'h1);
    check_all();
    step(); disp(OpFpu, 0, 0, 1, 12, 0, 0);
    expect_val("rs2_raw_cond", SelCond, 32'h0); check_all();
    step(); disp(OpFpu, 1, 13, 0, 12, 0, 0);
    expect_val("rs2_off_cond", SelCond, 32'h1); check_all();
    step();
    expect_val("final_cnt", SelCnt, 32'h160);
    expect_val("final_all_empty", SelAllEmpty, 32'h0);
    expect_val("final_err", SelErr, 32'h1);
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
